r2sdf_bf_stage: RTL
===================

# r2sdf_bf_stage

Radix-2 single-path delay-feedback (R2SDF) butterfly stage that drives the 8-deep complex delay line of the 32-point FFT pipeline. It streams one complex sample per cycle and computes scaled sum/difference butterflies between each sample and the sample DELAY cycles earlier. It writes to the delay line and reads it back, and emits a registered stream to the downstream twiddle multiplier.

## Interface
- WIDTH, 15: bits per real/imag component, two's complement.
- DELAY, 8: feedback delay-line depth; the butterfly span is 2*DELAY samples. Must be a power of two ≥2.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  high for every sample of a frame; frames are gap-free runs of 2*DELAY samples.
- in_r, in_i  in  WIDTH  input sample.
- sr_out_r, sr_out_i  in  WIDTH  delay-line output; the word written DELAY cycles earlier.
- sr_in_r, sr_in_i  out  WIDTH  delay-line input; combinational and driven every cycle.
- out_valid  out  1  registered output qualifier.
- out_r, out_i  out  WIDTH  registered butterfly output.
- err  out  1  sticky protocol-violation flag.

## Operation
- FSM states:
  - IDLE: waits for in_valid.
  - RUN: counter c counts 0..2*DELAY-1 modulo, advancing every cycle.
  - FLUSH: DELAY cycles that drain the final differences.
- IDLE → RUN on in_valid=1; that cycle is c=0.
- RUN at c wrap (2*DELAY-1 → 0):
  - in_valid=1 on the next cycle: stay in RUN (back-to-back frame).
  - else: go to FLUSH with c=0.
- FLUSH → IDLE after c=DELAY-1.
- RUN, c<DELAY (load phase):
  - sr_in = x.
  - Output candidate = sr_out, i.e. the previous frame's differences.
  - out_valid is asserted only if a previous frame exists.
- RUN, c≥DELAY (butterfly phase), with a=sr_out and b=x:
  - Output candidate = (a+b)>>>1.
  - sr_in = (a−b)>>>1.
  - out_valid is asserted.
- FLUSH: output candidate = sr_out, out_valid asserted, sr_in=0.
- IDLE: sr_in=0, out_valid=0.
- Arithmetic:
  - Sum and difference are computed at WIDTH+1 bits, then arithmetic-shifted right by 1 (floor).
  - The result always fits WIDTH bits, so no saturation is needed.
  - Real and imaginary parts are processed independently.
- Per-frame output order: DELAY sums (indices 0..DELAY-1), then DELAY differences.
- Protocol violations set err=1, which holds until rst:
  - in_valid=0 in RUN with c≠0: the missing sample is treated as x=0 and the counter keeps running.
  - in_valid=1 in FLUSH: the sample is ignored.
- Delay-line contents are not reset by this block. sr_out is never used before DELAY writes of the current run have occurred.

## Timing
- Output register: out_* and out_valid are updated one cycle after the combinational candidate.
- Latency:
  - First sample accepted at cycle 0.
  - First sum visible at cycle DELAY+1 (9).
  - First difference visible at cycle 2*DELAY+1 (17).
- A single frame produces 2*DELAY consecutive out_valid cycles (9..24).
- N back-to-back frames produce 2*DELAY*N consecutive out_valid cycles with no bubble.
- Delay line: sr_in driven in cycle t appears on sr_out in cycle t+DELAY.
- Reset:
  - Next cycle: out_r=out_i=0, out_valid=0, err=0, state IDLE, c=0.
  - Reset mid-RUN or mid-FLUSH aborts the frame; no further out_valid until a new frame has progressed DELAY+1 cycles.
- in_valid is sampled every cycle, including the wrap cycle and the last FLUSH cycle.
- A frame starting on the cycle after FLUSH ends is legal and starts from IDLE normally.

## Test plan
- Reset: assert rst for 2 cycles mid-stream → out_r=out_i=0, out_valid=0, err=0 on the following cycle; the next frame behaves as if first after reset.
- Single ramp frame, in_r=n for n=0..15, in_i=0:
  - Cycles 9..16: out_r=4,5,...,11 (the value n+4 for n=0..7).
  - Cycles 17..24: out_r=−4 (eight times).
  - out_i=0 throughout; out_valid=1 exactly on cycles 9..24; sr_in=0 after cycle 24.
- Two back-to-back frames, second frame in_r=100 constant:
  - out_valid high for cycles 9..40 without a gap.
  - Second frame's sums = 100; its differences = 0.
- Extremes:
  - All samples 16383 → sums 16383, diffs 0.
  - First half 16383, second half −16384 → sums −1, diffs 16383.
  - Imaginary part checked with the mirrored pattern.
- Rounding: a=−1, b=0 → sum −1, diff −1; a=1, b=0 → sum 0, diff 0.
- Protocol:
  - Drop in_valid at c=5 → err=1 from the next cycle and stays set; the zero sample is reflected in the outputs.
  - Raise in_valid during FLUSH → err=1, and the FLUSH outputs are unchanged.

Source files
------------

// File: rtl/r2sdf_bf_stage.sv
// Radix-2 single-path delay-feedback butterfly stage driving an external DELAY-deep complex delay line.
// state | meaning: IDLE = wait for frame start; RUN = load/butterfly over 2*DELAY samples; FLUSH = drain differences
module r2sdf_bf_stage #(
    parameter int WIDTH = 15,
    parameter int DELAY = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_r,
    input  logic [WIDTH-1:0] in_i,
    input  logic [WIDTH-1:0] sr_out_r,
    input  logic [WIDTH-1:0] sr_out_i,
    output logic [WIDTH-1:0] sr_in_r,
    output logic [WIDTH-1:0] sr_in_i,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_r,
    output logic [WIDTH-1:0] out_i,
    output logic             err
);

    localparam int CW = $clog2(2 * DELAY);
    localparam logic [CW-1:0] C_ZERO    = '0;
    localparam logic [CW-1:0] C_ONE     = CW'(1);
    localparam logic [CW-1:0] C_HALF    = CW'(DELAY);
    localparam logic [CW-1:0] C_LAST    = CW'(2 * DELAY - 1);
    localparam logic [CW-1:0] C_FL_LAST = CW'(DELAY - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic              have_prev;
    logic              err_set;
    logic [WIDTH-1:0]  x_r, x_i;
    logic signed [WIDTH:0] sum_r, sum_i, dif_r, dif_i;
    logic [WIDTH-1:0]  cand_r, cand_i;
    logic              cand_v;

    // a missing sample inside a frame is treated as zero
    assign x_r = in_valid ? in_r : '0;
    assign x_i = in_valid ? in_i : '0;

    assign sum_r = {sr_out_r[WIDTH-1], sr_out_r} + {x_r[WIDTH-1], x_r};
    assign sum_i = {sr_out_i[WIDTH-1], sr_out_i} + {x_i[WIDTH-1], x_i};
    assign dif_r = {sr_out_r[WIDTH-1], sr_out_r} - {x_r[WIDTH-1], x_r};
    assign dif_i = {sr_out_i[WIDTH-1], sr_out_i} - {x_i[WIDTH-1], x_i};

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sr_in_r   = '0;
        sr_in_i   = '0;
        cand_r    = '0;
        cand_i    = '0;
        cand_v    = 1'b0;
        err_set   = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = RUN;
                    cnt_nxt   = C_ONE;
                    sr_in_r   = in_r;
                    sr_in_i   = in_i;
                end
            end
            RUN: begin
                // no sample right after a wrap ends the run; this cycle is the first drain cycle
                if (cnt == C_ZERO && !in_valid) begin
                    cand_r    = sr_out_r;
                    cand_i    = sr_out_i;
                    cand_v    = 1'b1;
                    state_nxt = FLUSH;
                    cnt_nxt   = C_ONE;
                end else begin
                    cnt_nxt = cnt + C_ONE;
                    err_set = !in_valid;
                    if (cnt < C_HALF) begin
                        sr_in_r = x_r;
                        sr_in_i = x_i;
                        cand_v  = have_prev;
                        cand_r  = have_prev ? sr_out_r : '0;
                        cand_i  = have_prev ? sr_out_i : '0;
                    end else begin
                        sr_in_r = WIDTH'(dif_r >>> 1);
                        sr_in_i = WIDTH'(dif_i >>> 1);
                        cand_r  = WIDTH'(sum_r >>> 1);
                        cand_i  = WIDTH'(sum_i >>> 1);
                        cand_v  = 1'b1;
                    end
                end
            end
            FLUSH: begin
                cand_r  = sr_out_r;
                cand_i  = sr_out_i;
                cand_v  = 1'b1;
                err_set = in_valid;
                cnt_nxt = cnt + C_ONE;
                if (cnt == C_FL_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = C_ZERO;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = C_ZERO;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= C_ZERO;
            have_prev <= 1'b0;
            out_r     <= '0;
            out_i     <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            if (state == IDLE)
                have_prev <= 1'b0;
            else if (state == RUN && cnt == C_LAST)
                have_prev <= 1'b1;
            out_r     <= cand_r;
            out_i     <= cand_i;
            out_valid <= cand_v;
            err       <= err | err_set;
        end
    end

endmodule
